// File: rtl/ntt_out_reorder.sv
// ntt_out_reorder: ping-pong buffer turning bit-reversed dual-lane NTT output into natural-order beats.
// Define NTT_REORDER_OVF_EN to enable the sticky ovf flag and the no-overflow assertion.
module ntt_out_reorder #(
  parameter int DATA_WIDTH = 12,
  parameter int N          = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_en,
  input  logic [2*DATA_WIDTH-1:0] in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out,
  output logic                    out_last,
  output logic                    ovf
);
  localparam int LOG_N = $clog2(N);
  localparam int CW = LOG_N - 1;
  localparam logic [CW-1:0] LAST = '1;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;
  bank_st_t st [2];
  bank_st_t st_nxt [2];
  logic wr_sel, rd_sel;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic wr_fire, wr_done, rd_fire, rd_done;
  logic [DATA_WIDTH-1:0] mem [2][N];
  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] x);
    logic [LOG_N-1:0] r;
    for (int i = 0; i < LOG_N; i++) r[i] = x[LOG_N-1-i];
    return r;
  endfunction
  always_comb begin
    wr_fire   = in_en && (st[wr_sel] == EMPTY || st[wr_sel] == FILLING);
    wr_done   = wr_fire && wr_cnt == LAST;
    out_valid = st[rd_sel] == FULL || st[rd_sel] == DRAINING;
    rd_fire   = out_valid && out_ready;
    rd_done   = rd_fire && rd_cnt == LAST;
    out_last  = out_valid && rd_cnt == LAST;
    out       = out_valid ? {mem[rd_sel][{rd_cnt, 1'b1}], mem[rd_sel][{rd_cnt, 1'b0}]} : '0;
    // a bank is never filling and draining at once, so write and read updates are exclusive
    for (int i = 0; i < 2; i++)
      st_nxt[i] = (wr_fire && wr_sel == 1'(i)) ? (wr_done ? FULL : FILLING) :
                  (rd_fire && rd_sel == 1'(i)) ? (rd_done ? EMPTY : DRAINING) : st[i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st[0]  <= EMPTY;
      st[1]  <= EMPTY;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      st     <= st_nxt;
      wr_sel <= wr_sel ^ wr_done;
      rd_sel <= rd_sel ^ rd_done;
      if (wr_fire) wr_cnt <= wr_cnt + CW'(1);
      if (rd_fire) rd_cnt <= rd_cnt + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_sel][bitrev({wr_cnt, 1'b0})] <= in[DATA_WIDTH-1:0];
      mem[wr_sel][bitrev({wr_cnt, 1'b1})] <= in[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end
`ifdef NTT_REORDER_OVF_EN
  logic drop;
  assign drop = in_en && !wr_fire;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end
  a_no_drop_when_ready: assert property (@(posedge clk) disable iff (rst) out_ready |-> !drop);
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_ntt_out_reorder.sv
// tb_ntt_out_reorder: random and directed stimulus checked against a polynomial-queue reference model.
module tb_ntt_out_reorder;
  localparam int DW = 12;
  localparam int N = 256;
  localparam int LOG_N = $clog2(N);
  localparam int HB = N / 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_en = 1'b0;
  logic out_ready = 1'b0;
  logic [2*DW-1:0] in_d = '0;
  logic [2*DW-1:0] out_d;
  logic out_valid, out_last, ovf;
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] fill [N];
  int n_polys = 0;
  int fill_cnt = 0;
  int rd_m = 0;
  bit ovf_m = 1'b0;
  always #5 clk = ~clk;
  ntt_out_reorder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in(in_d),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_d),
    .out_last(out_last), .ovf(ovf)
  );
  function automatic int bitrev(input int x);
    int r = 0;
    for (int i = 0; i < LOG_N; i++) r |= ((x >> i) & 1) << (LOG_N - 1 - i);
    return r;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    exp_q.delete();
    n_polys = 0;
    fill_cnt = 0;
    rd_m = 0;
    ovf_m = 1'b0;
  endtask
  task automatic step(input bit en, input logic [2*DW-1:0] d, input bit rdy);
    bit v, acc_w;
    logic [2*DW-1:0] exp_out;
    @(negedge clk);
    in_en = en;
    in_d = d;
    out_ready = rdy;
    v = n_polys > 0;
    exp_out = '0;
    if (v) exp_out = {exp_q[1], exp_q[0]};
    check("out_valid", 64'(out_valid), 64'(v));
    check("out", 64'(out_d), 64'(exp_out));
    check("out_last", 64'(out_last), 64'(v && rd_m == HB - 1));
    check("ovf", 64'(ovf), 64'(ovf_m));
    acc_w = en && (fill_cnt > 0 || n_polys < 2);
    if (v && rdy) begin
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      rd_m++;
      if (rd_m == HB) begin
        rd_m = 0;
        n_polys--;
      end
    end
    if (acc_w) begin
      fill[bitrev(2 * fill_cnt)] = d[DW-1:0];
      fill[bitrev(2 * fill_cnt + 1)] = d[2*DW-1:DW];
      fill_cnt++;
      if (fill_cnt == HB) begin
        for (int i = 0; i < N; i++) exp_q.push_back(fill[i]);
        n_polys++;
        fill_cnt = 0;
      end
    end else if (en) begin
`ifdef NTT_REORDER_OVF_EN
      ovf_m = 1'b1;
`endif
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    in_en = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out", 64'(out_d), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic drain(input int cycles);
    for (int c = 0; c < cycles; c++) step(1'b0, '0, 1'b1);
  endtask
  task automatic seq_poly(input bit rdy);
    for (int k = 0; k < HB; k++)
      step(1'b1, {DW'(bitrev(2 * k + 1)), DW'(bitrev(2 * k))}, rdy);
  endtask
  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    seq_poly(1'b1);
    drain(HB + 4);
    for (int k = 0; k < N; k++) step(1'b1, (2*DW)'($urandom()), 1'b1);
    drain(HB + 4);
    for (int k = 0; k < HB; k++) step(1'b1, (2*DW)'($urandom()), 1'b1);
    for (int c = 0; c < 2 * HB + 20; c++) step(1'b0, '0, pat[c % 4]);
    drain(8);
    for (int k = 0; k < 3 * HB; k++) step(1'b1, (2*DW)'($urandom()), 1'b0);
    drain(N + 4);
    check("poly4_all_drained", 64'(out_valid), 64'(0));
    do_reset();
    for (int k = 0; k < HB; k++) begin
      step(1'b1, {DW'(bitrev(2 * k + 1)), DW'(bitrev(2 * k))}, 1'b1);
      step(1'b0, '0, 1'b1);
    end
    drain(HB + 4);
    for (int k = 0; k < 60; k++) step(1'b1, (2*DW)'($urandom()), 1'b1);
    do_reset();
    for (int k = 0; k < HB; k++) step(1'b1, (2*DW)'($urandom()), 1'b0);
    drain(40);
    do_reset();
    seq_poly(1'b1);
    drain(HB + 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
